pixie_dma_fetch: RTL

DMA-out sequencer sitting directly upstream of the Studio II 1861 (Pixie) video stage. It watches the video stage's active-low DMA request and steals CPU machine cycles, one byte per cycle. For each stolen cycle it reads display RAM at the R0 pointer and presents the byte with the DMA state code `SC=2'b10`, which the video stage consumes as `data_in`. It owns R0 line-repeat rewinding (four scanlines per byte row) and the R0 frame reload on the display interrupt.

---
 rtl/pixie_dma_fetch.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/pixie_dma_fetch.sv
// DMA-out sequencer feeding the 1861 video stage: steals one machine cycle per
// byte, reads display RAM at R0 and manages the line-repeat rewind and frame reload.
module pixie_dma_fetch #(
    parameter logic [15:0] BASE_ADDR      = 16'h0900,
    parameter int          BYTES_PER_LINE = 8,
    parameter int          LINE_REPEAT    = 4,
    parameter bit          WRAP_EN        = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk_enable,
    input  logic        dmao_n,
    input  logic        int_in,
    input  logic        r0_load,
    input  logic [15:0] r0_value,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_data,
    output logic [1:0]  SC,
    output logic        cpu_hold,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic [15:0] r0
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_FETCH,
        S_CAPTURE,
        S_HOLD
    } state_t;

    localparam logic [1:0]  SC_DMA   = 2'b10;
    localparam logic [1:0]  SC_EXEC  = 2'b01;
    localparam logic [3:0]  BPL      = 4'(BYTES_PER_LINE);
    localparam logic [3:0]  LREP     = 4'(LINE_REPEAT);
    localparam logic [15:0] STEP_ONE = 16'd1;
    localparam logic [15:0] REWIND   = 16'(0 - BYTES_PER_LINE);

    state_t      state;
    logic [3:0]  byte_cnt;
    logic [3:0]  rep_cnt;
    logic        int_d;

    logic        int_rise;
    logic        burst_go;
    logic        hold_end;
    logic        full_end;
    logic [3:0]  rep_inc;
    logic [15:0] r0_nxt;
    logic [3:0]  byte_nxt;
    logic [3:0]  rep_nxt;

    // With WRAP_EN the pointer lives in a 256-byte window starting at BASE_ADDR.
    function automatic logic [15:0] r0_step(input logic [15:0] cur, input logic [15:0] delta);
        logic [15:0] off;
        if (WRAP_EN) begin
            off = cur - BASE_ADDR + delta;
            return BASE_ADDR + (off & 16'h00FF);
        end
        return cur + delta;
    endfunction

    assign int_rise = int_in & ~int_d;
    assign burst_go = clk_enable && !dmao_n && (byte_cnt < BPL);
    assign hold_end = (state == S_HOLD) && clk_enable && !burst_go;
    assign full_end = hold_end && (byte_cnt == BPL);
    assign rep_inc  = rep_cnt + 4'd1;

    // R0 and counter updates; later assignments carry higher priority.
    always_comb begin
        r0_nxt   = r0;
        byte_nxt = byte_cnt;
        rep_nxt  = rep_cnt;
        if (state == S_CAPTURE) begin
            r0_nxt   = r0_step(r0, STEP_ONE);
            byte_nxt = byte_cnt + 4'd1;
        end
        if (hold_end) begin
            byte_nxt = 4'd0;
            if (full_end) begin
                if (rep_inc < LREP) begin
                    rep_nxt = rep_inc;
                    r0_nxt  = r0_step(r0, REWIND);
                end else begin
                    rep_nxt = 4'd0;
                end
            end
        end
        if (int_rise) begin
            r0_nxt   = BASE_ADDR;
            byte_nxt = 4'd0;
            rep_nxt  = 4'd0;
        end
        if (r0_load) begin
            r0_nxt = r0_value;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            r0         <= BASE_ADDR;
            mem_addr   <= 16'h0000;
            mem_rd     <= 1'b0;
            SC         <= SC_EXEC;
            cpu_hold   <= 1'b0;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            byte_cnt   <= 4'd0;
            rep_cnt    <= 4'd0;
            int_d      <= 1'b0;
        end else begin
            int_d      <= int_in;
            r0         <= r0_nxt;
            byte_cnt   <= byte_nxt;
            rep_cnt    <= rep_nxt;
            mem_rd     <= 1'b0;
            data_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (clk_enable && !dmao_n) begin
                        state    <= S_ARM;
                        SC       <= SC_DMA;
                        cpu_hold <= 1'b1;
                    end
                end
                S_ARM: begin
                    state    <= S_FETCH;
                    mem_addr <= r0;
                    mem_rd   <= 1'b1;
                end
                S_FETCH: begin
                    state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    state      <= S_HOLD;
                    data_out   <= mem_data;
                    data_valid <= 1'b1;
                end
                S_HOLD: begin
                    if (clk_enable) begin
                        if (burst_go) begin
                            state <= S_ARM;
                        end else begin
                            state    <= S_IDLE;
                            SC       <= SC_EXEC;
                            cpu_hold <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    SC       <= SC_EXEC;
                    cpu_hold <= 1'b0;
                end
            endcase
        end
    end

endmodule
